// File: rtl/icache_refill_ctrl_if.sv
// Memory read port between the refill controller (master) and the memory system (slave).
// One read beat returns per granted request.
interface icache_refill_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction cache line refill: fetches the four words of a missing line in order,
// writes them to the data array, then validates the tag unless a flush aborted it.
module icache_refill_ctrl #(
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned TAG_W      = 22,
  parameter  int unsigned INDEX_W    = 6,
  parameter  int unsigned LINE_WORDS = 4,
  localparam int unsigned WORD_W     = $clog2(LINE_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_req,
  input  logic [ADDR_W-1:0]   miss_addr,
  input  logic                flush_req,
  output logic                refill_busy,
  output logic                refill_done,
  icache_refill_ctrl_if.master mem,
  output logic                data_we,
  output logic [INDEX_W-1:0]  data_index,
  output logic [WORD_W-1:0]   data_word,
  output logic [31:0]         data_wdata,
  output logic                update_valid,
  output logic [INDEX_W-1:0]  update_index,
  output logic [TAG_W-1:0]    update_tag,
  output logic                flush_all
);

  localparam logic [WORD_W-1:0] LastWord = WORD_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StTag, StDone} state_e;

  state_e             state_q;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] index_q;
  logic [WORD_W-1:0]  cnt_q;
  logic               abort_q;
  logic               flush_all_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      index_q     <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      flush_all_q <= 1'b0;
    end else begin
      flush_all_q <= flush_req;
      if (flush_req && state_q != StIdle) abort_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (miss_req) begin
            tag_q   <= miss_addr[ADDR_W-1 -: TAG_W];
            index_q <= miss_addr[ADDR_W-TAG_W-1 -: INDEX_W];
            cnt_q   <= '0;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (mem.gnt) state_q <= StWait;
        end
        StWait: begin
          if (mem.rvalid) begin
            if (cnt_q == LastWord) begin
              state_q <= StTag;
            end else begin
              cnt_q   <= cnt_q + WORD_W'(1);
              state_q <= StReq;
            end
          end
        end
        StTag: state_q <= StDone;
        StDone: begin
          // Clearing here outranks a flush landing in the same cycle.
          abort_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    refill_busy  = (state_q != StIdle);
    refill_done  = (state_q == StDone);
    mem.req      = (state_q == StReq);
    mem.addr     = {tag_q, index_q, cnt_q, 2'b00};
    data_we      = (state_q == StWait) && mem.rvalid;
    data_index   = index_q;
    data_word    = cnt_q;
    data_wdata   = data_we ? mem.rdata : '0;
    // A flush in the tag cycle itself wins over the validate.
    update_valid = (state_q == StTag) && !abort_q && !flush_req && !rst;
    update_index = index_q;
    update_tag   = tag_q;
    flush_all    = flush_all_q;
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a cycle-level memory responder.
module tb_icache_refill_ctrl;
  logic        clk = 1'b0;
  logic        rst, miss_req, flush_req;
  logic [31:0] miss_addr;
  logic        refill_busy, refill_done, data_we, update_valid, flush_all;
  logic [5:0]  data_index, update_index;
  logic [1:0]  data_word;
  logic [31:0] data_wdata;
  logic [21:0] update_tag;

  icache_refill_ctrl_if #(.ADDR_W(32)) mem_if ();

  icache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr), .flush_req(flush_req),
    .refill_busy(refill_busy), .refill_done(refill_done), .mem(mem_if),
    .data_we(data_we), .data_index(data_index), .data_word(data_word), .data_wdata(data_wdata),
    .update_valid(update_valid), .update_index(update_index), .update_tag(update_tag),
    .flush_all(flush_all)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Memory model and observation records
  int          wcnt, beat;
  bit          pend;
  int          n_we, n_gnt, n_uv, n_fa, n_done, both, unstable, first_req, done_cyc, fa_cyc;
  int          extra_busy, we_after_rst;
  bit          zero_after_rst, hold_pending;
  logic [31:0] prev_addr;
  logic [1:0]  we_word [8];
  logic [31:0] we_data [8];
  logic [5:0]  we_index[8];
  logic [31:0] gnt_addr[8];
  logic [21:0] uv_tag;
  logic [5:0]  uv_index;

  function automatic bit outs_zero();
    return ({refill_busy, refill_done, mem_if.req, mem_if.addr, data_we, data_index, data_word,
             data_wdata, update_valid, update_index, update_tag, flush_all} == '0);
  endfunction

  task automatic idle_inputs();
    @(negedge clk);
    rst = 0; miss_req = 0; flush_req = 0;
    mem_if.gnt = 0; mem_if.rvalid = 0; mem_if.rdata = '0;
  endtask

  task automatic run(input logic [31:0] addr, input logic [31:0] base, input int delay,
                     input int flush_at, input int miss2_at, input logic [31:0] addr2,
                     input int rst_at, input int limit);
    wcnt = 0; beat = 0; pend = 0;
    n_we = 0; n_gnt = 0; n_uv = 0; n_fa = 0; n_done = 0; both = 0; unstable = 0;
    first_req = -1; done_cyc = -1; fa_cyc = -1; extra_busy = 0; we_after_rst = 0;
    zero_after_rst = 0; hold_pending = 0; prev_addr = '0; uv_tag = '0; uv_index = '0;
    for (int cyc = 0; cyc <= limit; cyc++) begin
      @(negedge clk);
      rst       = (cyc == rst_at);
      miss_req  = (cyc == 0) || (cyc == miss2_at);
      miss_addr = (cyc == miss2_at) ? addr2 : addr;
      flush_req = (cyc == flush_at);
      mem_if.rvalid = pend;
      mem_if.rdata  = pend ? base + 32'(beat) : 32'hDEAD_BEEF;
      if (pend) begin pend = 0; beat++; end
      mem_if.gnt = 0;
      if (mem_if.req) begin
        if (wcnt == delay) begin mem_if.gnt = 1; wcnt = 0; pend = 1; end
        else wcnt++;
      end
      if (cyc == rst_at) pend = 1;  // stray beat arriving after the reset
      #1;
      if (hold_pending && (!mem_if.req || mem_if.addr !== prev_addr)) unstable++;
      hold_pending = mem_if.req && !mem_if.gnt;
      prev_addr    = mem_if.addr;
      if (mem_if.req && first_req < 0) first_req = cyc;
      if (mem_if.req && mem_if.gnt && n_gnt < 8) begin gnt_addr[n_gnt] = mem_if.addr; n_gnt++; end
      if (data_we) begin
        if (n_we < 8) begin
          we_word[n_we] = data_word; we_data[n_we] = data_wdata; we_index[n_we] = data_index;
        end
        n_we++;
        if (rst_at >= 0 && cyc > rst_at) we_after_rst++;
      end
      if (update_valid) begin n_uv++; uv_tag = update_tag; uv_index = update_index; end
      if (flush_all) begin n_fa++; if (fa_cyc < 0) fa_cyc = cyc; end
      if (update_valid && flush_all) both++;
      if (refill_done) begin n_done++; if (done_cyc < 0) done_cyc = cyc; end
      if (done_cyc >= 0 && cyc > done_cyc && refill_busy) extra_busy++;
      if (rst_at >= 0 && cyc == rst_at + 1) zero_after_rst = outs_zero();
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; miss_req = 1; miss_addr = 32'hFFFF_FFF0; flush_req = 0;
    mem_if.gnt = 1; mem_if.rvalid = 1; mem_if.rdata = 32'h5555_AAAA;
    @(negedge clk);
    @(negedge clk);
    miss_req = 0; mem_if.gnt = 0; mem_if.rvalid = 0;
    #1;
    total++;
    if (!outs_zero()) $display("FAIL reset_outputs got nonzero want all zero");
    else passed++;
    idle_inputs();
    #1;
    total++;
    if (refill_busy !== 1'b0) $display("FAIL reset_idle busy got %b want 0", refill_busy);
    else passed++;
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    flush_req = 1;
    @(negedge clk);
    flush_req = 0;
    #1;
    total++;
    if (flush_all !== 1'b1) $display("FAIL flush_idle_strobe got %b want 1", flush_all);
    else passed++;
    total++;
    if (refill_busy !== 1'b0) $display("FAIL flush_idle_busy got %b want 0", refill_busy);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (flush_all !== 1'b0) $display("FAIL flush_idle_pulse got %b want 0", flush_all);
    else passed++;
  endtask

  task automatic test_basic_refill();
    run(32'h1234_5670, 32'hA0, 0, -1, -1, '0, -1, 40);
    total++;
    if (first_req !== 1) $display("FAIL basic_req_latency got %0d want 1", first_req);
    else passed++;
    total++;
    if (n_gnt !== 4) $display("FAIL basic_gnt_count got %0d want 4", n_gnt);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (gnt_addr[i] !== 32'h1234_5670 + 32'(4 * i))
        $display("FAIL basic_mem_addr[%0d] got %h want %h", i, gnt_addr[i], 32'h1234_5670 + 32'(4 * i));
      else passed++;
      total++;
      if (we_word[i] !== 2'(i) || we_data[i] !== 32'hA0 + 32'(i) || we_index[i] !== 6'h27)
        $display("FAIL basic_write[%0d] got w%0d d%h i%h want w%0d d%h i27", i, we_word[i],
                 we_data[i], we_index[i], i, 32'hA0 + 32'(i));
      else passed++;
    end
    total++;
    if (n_we !== 4) $display("FAIL basic_we_count got %0d want 4", n_we);
    else passed++;
    total++;
    if (n_uv !== 1 || uv_tag !== 22'h048D15 || uv_index !== 6'h27)
      $display("FAIL basic_update got n%0d t%h i%h want n1 t048d15 i27", n_uv, uv_tag, uv_index);
    else passed++;
    total++;
    if (done_cyc !== 10 || n_done !== 1)
      $display("FAIL basic_done got c%0d n%0d want c10 n1", done_cyc, n_done);
    else passed++;
    total++;
    if (n_fa !== 0) $display("FAIL basic_no_flush got %0d want 0", n_fa);
    else passed++;
  endtask

  task automatic test_gnt_delay();
    run(32'h0000_ABC8, 32'h300, 3, -1, -1, '0, -1, 60);
    total++;
    if (unstable !== 0) $display("FAIL delay_req_stable got %0d want 0", unstable);
    else passed++;
    total++;
    if (n_gnt !== 4 || n_we !== 4) $display("FAIL delay_beats got g%0d w%0d want g4 w4", n_gnt, n_we);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (gnt_addr[i] !== 32'h0000_ABC0 + 32'(4 * i) || we_word[i] !== 2'(i))
        $display("FAIL delay_word[%0d] got a%h w%0d want a%h w%0d", i, gnt_addr[i], we_word[i],
                 32'h0000_ABC0 + 32'(4 * i), i);
      else passed++;
    end
    total++;
    if (n_uv !== 1 || uv_tag !== 22'h00002A || uv_index !== 6'h3C)
      $display("FAIL delay_update got n%0d t%h i%h want n1 t00002a i3c", n_uv, uv_tag, uv_index);
    else passed++;
    total++;
    if (done_cyc !== 22) $display("FAIL delay_latency got %0d want 22", done_cyc);
    else passed++;
  endtask

  task automatic test_flush_mid_refill();
    run(32'h1234_5670, 32'hB0, 0, 6, -1, '0, -1, 40);
    total++;
    if (fa_cyc !== 7 || n_fa !== 1) $display("FAIL abort_flush_all got c%0d n%0d want c7 n1", fa_cyc, n_fa);
    else passed++;
    total++;
    if (n_we !== 4 || we_word[3] !== 2'd3 || we_data[2] !== 32'hB2)
      $display("FAIL abort_writes got n%0d w3=%0d d2=%h want n4 w3=3 d2=b2", n_we, we_word[3], we_data[2]);
    else passed++;
    total++;
    if (n_uv !== 0) $display("FAIL abort_no_update got %0d want 0", n_uv);
    else passed++;
    total++;
    if (done_cyc !== 10) $display("FAIL abort_done got %0d want 10", done_cyc);
    else passed++;
  endtask

  task automatic test_flush_tag_cycle();
    run(32'h0000_0400, 32'hC0, 0, 9, -1, '0, -1, 40);
    total++;
    if (n_uv !== 0) $display("FAIL tagflush_no_update got %0d want 0", n_uv);
    else passed++;
    total++;
    if (fa_cyc !== 10 || both !== 0) $display("FAIL tagflush_strobe got c%0d both%0d want c10 both0", fa_cyc, both);
    else passed++;
    total++;
    if (done_cyc !== 10) $display("FAIL tagflush_done got %0d want 10", done_cyc);
    else passed++;
  endtask

  task automatic test_reset_mid_refill();
    run(32'h1234_5670, 32'hD0, 0, -1, -1, '0, 4, 7);
    total++;
    if (zero_after_rst !== 1'b1) $display("FAIL rst_outputs got nonzero want all zero");
    else passed++;
    total++;
    if (we_after_rst !== 0 || n_uv !== 0)
      $display("FAIL rst_stray got we%0d uv%0d want we0 uv0", we_after_rst, n_uv);
    else passed++;
    total++;
    if (n_done !== 0) $display("FAIL rst_no_done got %0d want 0", n_done);
    else passed++;
    run(32'h0000_0010, 32'hE0, 0, -1, -1, '0, -1, 40);
    total++;
    if (n_uv !== 1 || uv_index !== 6'h01 || uv_tag !== 22'h0)
      $display("FAIL rst_refill_update got n%0d i%h t%h want n1 i01 t0", n_uv, uv_index, uv_tag);
    else passed++;
    total++;
    if (gnt_addr[0] !== 32'h10 || gnt_addr[3] !== 32'h1C || done_cyc !== 10)
      $display("FAIL rst_refill_addr got %h/%h c%0d want 10/1c c10", gnt_addr[0], gnt_addr[3], done_cyc);
    else passed++;
  endtask

  task automatic test_back_to_back();
    run(32'h0000_2020, 32'hF0, 0, -1, 4, 32'h0000_3330, -1, 40);
    total++;
    if (n_uv !== 1 || uv_index !== 6'h02 || uv_tag !== 22'h000008)
      $display("FAIL busy_miss_update got n%0d i%h t%h want n1 i02 t000008", n_uv, uv_index, uv_tag);
    else passed++;
    total++;
    if (n_gnt !== 4 || gnt_addr[3] !== 32'h0000_202C)
      $display("FAIL busy_miss_addr got n%0d a%h want n4 a0000202c", n_gnt, gnt_addr[3]);
    else passed++;
    total++;
    if (n_done !== 1 || extra_busy !== 0)
      $display("FAIL busy_miss_ignored got done%0d busy%0d want done1 busy0", n_done, extra_busy);
    else passed++;
  endtask

  initial begin
    rst = 1; miss_req = 0; flush_req = 0; miss_addr = '0;
    mem_if.gnt = 0; mem_if.rvalid = 0; mem_if.rdata = '0;
    test_reset();
    test_flush_idle();
    test_basic_refill();
    test_gnt_delay();
    test_flush_mid_refill();
    test_flush_tag_cycle();
    test_back_to_back();
    test_reset_mid_refill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
